// File: rtl/fxp_div_pipe_hs.sv
// Signed fixed-point restoring divider, Q(WIDTH-FRAC).FRAC operands and result.
// Valid/ready handshakes on both sides, one divide in flight at a time.
// The quotient saturates on overflow, and a zero divisor is flagged.
// The remainder is the raw magnitude ((|n| << FRAC) mod |d|).
module fxp_div_pipe_hs #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int TOT = WIDTH + FRAC;
  localparam int CW  = $clog2(TOT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [TOT-1:0]   dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rres_q, rres_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] nmag, dmag;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH:0]   rem_next;
  logic [TOT-1:0]   qmag;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign q           = quot_q;
  assign r           = rres_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

  // Operand magnitudes and one restoring step; the dividend register doubles
  // as the quotient register, shifting quotient bits in at the LSB.
  always_comb begin
    nmag     = n[WIDTH-1] ? (~n + 1'b1) : n;
    dmag     = d[WIDTH-1] ? (~d + 1'b1) : d;
    trial    = {rem_q, dvd_q[TOT-1]};
    qbit     = (trial >= {2'b00, dsr_q});
    rem_next = qbit ? (WIDTH+1)'(trial - {2'b00, dsr_q}) : trial[WIDTH:0];
    qmag     = {dvd_q[TOT-2:0], qbit};
  end

  // Next-state logic: accept, iterate, then form the saturated result as the
  // last quotient bit is produced so DONE is entered on the final step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dsr_d   = dsr_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    rres_d  = rres_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = n[WIDTH-1] ^ d[WIDTH-1];
          dsr_d  = dmag;
          if (d == '0) begin
            state_d = S_DONE;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            rres_d  = '0;
            quot_d  = n[WIDTH-1] ? MINN : MAXP;
          end else begin
            state_d = S_CALC;
            dvd_d   = TOT'(nmag) << FRAC;
            rem_d   = '0;
            cnt_d   = CW'(TOT);
          end
        end
      end
      S_CALC: begin
        rem_d = rem_next;
        dvd_d = qmag;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          dbz_d   = 1'b0;
          rres_d  = rem_next[WIDTH-1:0];
          if (!sign_q && (qmag > TOT'(MAXP))) begin
            quot_d = MAXP;
            ovf_d  = 1'b1;
          end else if (sign_q && (qmag > TOT'(MINN))) begin
            quot_d = MINN;
            ovf_d  = 1'b1;
          end else begin
            quot_d = sign_q ? (~qmag[WIDTH-1:0] + 1'b1) : qmag[WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      rres_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dsr_q   <= dsr_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      rres_q  <= rres_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_fxp_div_pipe_hs.sv
// Testbench for fxp_div_pipe_hs (WIDTH=32, FRAC=16): directed vectors with
// hand-computed results feed a scoreboard queue; a monitor pops on handshake.
module tb_fxp_div_pipe_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] n_i, d_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q, r;
  logic        overflow, div_by_zero;

  fxp_div_pipe_hs #(.WIDTH(32), .FRAC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n          (n_i),
    .d          (d_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;
    logic        dbz;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   rise_cyc   = 0;
  logic ov_prev    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: record out_valid rise, pop and compare on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got q=%h r=%h with nothing expected", q, r);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_q"},   64'(q),           64'(e.q));
        chk({e.name, "_r"},   64'(r),           64'(e.r));
        chk({e.name, "_ovf"}, 64'(overflow),    64'(e.ovf));
        chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        chk({e.name, "_lat"}, 64'(rise_cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] nn, input logic [31:0] dd,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic eo, input logic ez, input int el);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(posedge clk); #1;
    n_i = nn; d_i = dd; in_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.q = eq; e.r = er; e.ovf = eo; e.dbz = ez; e.lat = el;
        e.acc = cyc + 1; e.name = name;
        exp_q.push_back(e);
        got = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL %s_accept: got in_ready=0 for 300 cycles, required 1", name);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic [31:0] hq, hr;
    logic        ho, hz;
    bit          seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; n_i = '0; d_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_q_r",       {q, r},         64'd0);
    chk("reset_flags",     64'({overflow, div_by_zero}), 64'd0);

    issue("div_10_4",     32'h000A0000, 32'h00040000, 32'h00028000, 32'h0, 1'b0, 1'b0, 49);
    issue("div_m75_2",    32'hFFF88000, 32'h00020000, 32'hFFFC4000, 32'h0, 1'b0, 1'b0, 49);
    issue("div_75_m2",    32'h00078000, 32'hFFFE0000, 32'hFFFC4000, 32'h0, 1'b0, 1'b0, 49);
    issue("div_m75_m2",   32'hFFF88000, 32'hFFFE0000, 32'h0003C000, 32'h0, 1'b0, 1'b0, 49);
    issue("div_1_3",      32'h00010000, 32'h00030000, 32'h00005555, 32'h00010000, 1'b0, 1'b0, 49);
    issue("sat_pos",      32'h75300000, 32'h00008000, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 49);
    issue("sat_neg",      32'h8AD00000, 32'h00008000, 32'h80000000, 32'h0, 1'b1, 1'b0, 49);
    issue("min_div_1",    32'h80000000, 32'h00010000, 32'h80000000, 32'h0, 1'b0, 1'b0, 49);
    issue("min_div_m1",   32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 49);
    issue("dbz_neg",      32'hFFFF0000, 32'h00000000, 32'h80000000, 32'h0, 1'b0, 1'b1, 1);
    issue("dbz_pos",      32'h00050000, 32'h00000000, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1);
    issue("zero_num",     32'h00000000, 32'h00030000, 32'h00000000, 32'h0, 1'b0, 1'b0, 49);
    drain("directed");

    // Stall the consumer and offer a second operand pair during DONE.
    out_ready = 1'b0;
    issue("stall_10_4", 32'h000A0000, 32'h00040000, 32'h00028000, 32'h0, 1'b0, 1'b0, 49);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("stall_seen_valid", 64'(seen), 64'd1);
    hq = q; hr = r; ho = overflow; hz = div_by_zero;
    @(posedge clk); #1;
    n_i = 32'h00010000; d_i = 32'h00030000; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold_qr",    {q, r}, {hq, hr});
      chk("stall_hold_flags", 64'({overflow, div_by_zero, out_valid, in_ready}),
                              64'({ho, hz, 1'b1, 1'b0}));
    end
    chk("stall_sb_pending", 64'(exp_q.size()), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue("after_stall_1_3", 32'h00010000, 32'h00030000, 32'h00005555, 32'h00010000, 1'b0, 1'b0, 49);
    drain("stall");

    // Reset in the middle of CALC abandons the operation.
    issue("abort_10_4", 32'h000A0000, 32'h00040000, 32'h00028000, 32'h0, 1'b0, 1'b0, 49);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready",  64'(in_ready),  64'd1);
    chk("midreset_q",         64'(q),         64'd0);
    repeat (60) @(negedge clk);
    chk("midreset_no_result", 64'(out_valid), 64'd0);
    issue("post_reset_10_4", 32'h000A0000, 32'h00040000, 32'h00028000, 32'h0, 1'b0, 1'b0, 49);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
